// File: rtl/sprite_blitter_pkg.sv
// Shared constants and types for the sprite blitter.
//
// Contents:
//   BLIT_OP_*         command opcodes, also used by the CPU.
//   FB_BYTES_PER_ROW  bytes in one physical frame-buffer row (128 px / 8).
//   FB_BYTES          total frame-buffer size in bytes.
//   state_t           blitter sequencer states.
package sprite_blitter_pkg;

    localparam logic [2:0] BLIT_OP_NONE   = 3'd0;
    localparam logic [2:0] BLIT_OP_SPRITE = 3'd1;
    localparam logic [2:0] BLIT_OP_CLEAR  = 3'd2;

    localparam int FB_BYTES_PER_ROW = 16;
    localparam int FB_BYTES         = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NOOP,
        ST_FETCH,
        ST_RD_L,
        ST_RD_R,
        ST_WR_L,
        ST_WR_R,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/sprite_blitter_shift.sv
// Combinational sprite-row aligner.
//
// Places an 8-pixel sprite byte at a sub-byte pixel offset, producing the XOR
// masks for the two frame-buffer bytes it can straddle.
//
// Ports:
//   data    [7:0]  sprite byte, bit 7 = leftmost pixel
//   shift   [2:0]  pixel offset within the left byte (x0[2:0])
//   clip_r         1 = right byte is off-screen or unused
//   mask_l  [7:0]  XOR mask for the left byte
//   mask_r  [7:0]  XOR mask for the right byte, zero when clipped
module blit_shift (
    input  logic [7:0] data,
    input  logic [2:0] shift,
    input  logic       clip_r,
    output logic [7:0] mask_l,
    output logic [7:0] mask_r
);

    logic [15:0] shifted;

    always_comb begin
        shifted = {data, 8'h00} >> shift;
        mask_l  = shifted[15:8];
        mask_r  = clip_r ? 8'h00 : shifted[7:0];
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: executes CPU draw commands against the 1 KiB monochrome
// frame buffer. Supports XOR sprite drawing with collision detection and a
// full-buffer clear.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   hires                        1 = 128x64 logical screen, 0 = 64x32
//   blit_op/src/srcHeight/destX/destY/enable   command from the CPU
//   blit_busy, blit_done         status: in progress, one-cycle completion
//   blit_collision               a set pixel was cleared by the last sprite
//   src_en/src_addr/src_data     main-RAM read port (1-cycle latency)
//   vram_en/vram_wr/vram_addr/vram_in/vram_out  frame-buffer port
//                                (1-cycle read latency)
module sprite_blitter
    import sprite_blitter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hires,
    input  logic [2:0]  blit_op,
    input  logic [11:0] blit_src,
    input  logic [3:0]  blit_srcHeight,
    input  logic [6:0]  blit_destX,
    input  logic [5:0]  blit_destY,
    input  logic        blit_enable,
    output logic        blit_busy,
    output logic        blit_done,
    output logic        blit_collision,
    output logic        src_en,
    output logic [11:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        vram_en,
    output logic        vram_wr,
    output logic [9:0]  vram_addr,
    output logic [7:0]  vram_in,
    input  logic [7:0]  vram_out
);

    state_t state, next_state;

    // Latched command
    logic [11:0] src_q;
    logic [3:0]  height_q;
    logic [6:0]  x0_q;
    logic [5:0]  y0_q;
    logic        hires_q;

    // Row datapath
    logic [3:0]  row_q;
    logic [7:0]  s_q;
    logic [7:0]  old_l_q;
    logic [7:0]  old_r_q;
    logic        collision_q;
    logic        done_q;
    logic [9:0]  clr_cnt_q;

    // Origin wrap applied at accept so the datapath only ever sees
    // on-screen coordinates.
    logic [6:0] x0_in;
    logic [5:0] y0_in;

    assign x0_in = hires ? blit_destX : {1'b0, blit_destX[5:0]};
    assign y0_in = hires ? blit_destY : {1'b0, blit_destY[4:0]};

    // Row geometry
    logic [4:0] right_idx;
    logic [4:0] row_bytes;
    logic       clip_r;
    logic [5:0] y_cur;
    logic [6:0] y_next;
    logic [6:0] screen_h;
    logic [4:0] row_next;
    logic       last_row;
    logic [9:0] addr_l;
    logic [9:0] addr_r;
    logic [7:0] mask_l;
    logic [7:0] mask_r;

    always_comb begin
        right_idx = {1'b0, x0_q[6:3]} + 5'd1;
        row_bytes = hires_q ? 5'd16 : 5'd8;
        // A byte-aligned sprite never touches the right byte.
        clip_r    = (x0_q[2:0] == 3'd0) || (right_idx >= row_bytes);
        y_cur     = y0_q + {2'b00, row_q};
        y_next    = {1'b0, y0_q} + {3'b000, row_q} + 7'd1;
        screen_h  = hires_q ? 7'd64 : 7'd32;
        row_next  = {1'b0, row_q} + 5'd1;
        // Bottom edge truncates the sprite rather than wrapping it.
        last_row  = (row_next == {1'b0, height_q}) || (y_next >= screen_h);
        addr_l    = {y_cur, x0_q[6:3]};
        addr_r    = {y_cur, right_idx[3:0]};
    end

    blit_shift u_shift (
        .data   (s_q),
        .shift  (x0_q[2:0]),
        .clip_r (clip_r),
        .mask_l (mask_l),
        .mask_r (mask_r)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (blit_enable) begin
                    if (blit_op == BLIT_OP_SPRITE && blit_srcHeight != 4'd0) begin
                        next_state = ST_FETCH;
                    end else if (blit_op == BLIT_OP_CLEAR) begin
                        next_state = ST_CLEAR;
                    end else begin
                        next_state = ST_NOOP;
                    end
                end
            end
            ST_NOOP:  next_state = ST_IDLE;
            ST_FETCH: next_state = ST_RD_L;
            ST_RD_L:  next_state = ST_RD_R;
            ST_RD_R:  next_state = ST_WR_L;
            ST_WR_L:  next_state = ST_WR_R;
            ST_WR_R:  next_state = last_row ? ST_IDLE : ST_FETCH;
            ST_CLEAR: next_state = (clr_cnt_q == 10'(FB_BYTES - 1)) ? ST_IDLE : ST_CLEAR;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        blit_busy = (state != ST_IDLE);
        src_en    = 1'b0;
        src_addr  = 12'h000;
        vram_en   = 1'b0;
        vram_wr   = 1'b0;
        vram_addr = 10'h000;
        vram_in   = 8'h00;
        case (state)
            ST_FETCH: begin
                src_en   = 1'b1;
                src_addr = src_q + {8'h00, row_q};
            end
            ST_RD_L: begin
                vram_en   = 1'b1;
                vram_addr = addr_l;
            end
            ST_RD_R: begin
                vram_en   = !clip_r;
                vram_addr = addr_r;
            end
            ST_WR_L: begin
                vram_en   = 1'b1;
                vram_wr   = 1'b1;
                vram_addr = addr_l;
                vram_in   = old_l_q ^ mask_l;
            end
            ST_WR_R: begin
                vram_en   = !clip_r;
                vram_wr   = !clip_r;
                vram_addr = addr_r;
                vram_in   = old_r_q ^ mask_r;
            end
            ST_CLEAR: begin
                vram_en   = 1'b1;
                vram_wr   = 1'b1;
                vram_addr = clr_cnt_q;
            end
            default: ;
        endcase
    end

    // Command latch and row datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '0;
            height_q    <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            hires_q     <= 1'b0;
            row_q       <= '0;
            s_q         <= '0;
            old_l_q     <= '0;
            old_r_q     <= '0;
            collision_q <= 1'b0;
            done_q      <= 1'b0;
            clr_cnt_q   <= '0;
        end else begin
            // Done lands in the first IDLE cycle after any busy period.
            done_q <= (state != ST_IDLE) && (next_state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (blit_enable) begin
                        src_q       <= blit_src;
                        height_q    <= blit_srcHeight;
                        x0_q        <= x0_in;
                        y0_q        <= y0_in;
                        hires_q     <= hires;
                        row_q       <= '0;
                        clr_cnt_q   <= '0;
                        collision_q <= 1'b0;
                    end
                end
                ST_RD_L: s_q     <= src_data;
                ST_RD_R: old_l_q <= vram_out;
                ST_WR_L: begin
                    old_r_q <= clip_r ? 8'h00 : vram_out;
                    if ((old_l_q & mask_l) != 8'h00) collision_q <= 1'b1;
                end
                ST_WR_R: begin
                    // mask_r is zero when clipped, so a clipped byte never collides.
                    if ((old_r_q & mask_r) != 8'h00) collision_q <= 1'b1;
                    row_q <= row_q + 4'd1;
                end
                ST_CLEAR: clr_cnt_q <= clr_cnt_q + 10'd1;
                default: ;
            endcase
        end
    end

    assign blit_done      = done_q;
    assign blit_collision = collision_q;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
    import sprite_blitter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hires = 1'b0;
    logic [2:0]  blit_op = 3'd0;
    logic [11:0] blit_src = 12'h000;
    logic [3:0]  blit_srcHeight = 4'd0;
    logic [6:0]  blit_destX = 7'd0;
    logic [5:0]  blit_destY = 6'd0;
    logic        blit_enable = 1'b0;
    logic        blit_busy, blit_done, blit_collision;
    logic        src_en;
    logic [11:0] src_addr;
    logic [7:0]  src_data = 8'h00;
    logic        vram_en, vram_wr;
    logic [9:0]  vram_addr;
    logic [7:0]  vram_in;
    logic [7:0]  vram_out = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_mem  [4096];
    logic [7:0] vram_mem [1024];

    int         wr_count;
    logic       seq_bad;
    logic [9:0] wr_log [4];

    sprite_blitter dut (
        .clk            (clk),
        .rst            (rst),
        .hires          (hires),
        .blit_op        (blit_op),
        .blit_src       (blit_src),
        .blit_srcHeight (blit_srcHeight),
        .blit_destX     (blit_destX),
        .blit_destY     (blit_destY),
        .blit_enable    (blit_enable),
        .blit_busy      (blit_busy),
        .blit_done      (blit_done),
        .blit_collision (blit_collision),
        .src_en         (src_en),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .vram_en        (vram_en),
        .vram_wr        (vram_wr),
        .vram_addr      (vram_addr),
        .vram_in        (vram_in),
        .vram_out       (vram_out)
    );

    always #5 clk = ~clk;

    // Memory models with one-cycle read latency, plus a write logger.
    always @(posedge clk) begin
        if (src_en) src_data <= src_mem[src_addr];
        if (vram_en) begin
            vram_out <= vram_mem[vram_addr];
            if (vram_wr) begin
                vram_mem[vram_addr] <= vram_in;
                if (vram_addr != wr_count[9:0] || vram_in != 8'h00) seq_bad = 1'b1;
                if (wr_count < 4) wr_log[wr_count] = vram_addr;
                wr_count = wr_count + 1;
            end
        end
        if (vram_wr && !vram_en) seq_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_count = 0;
        seq_bad  = 1'b0;
        for (int i = 0; i < 4; i++) wr_log[i] = 10'h3FF;
    endtask

    // Issue one command and run it to completion; reports busy length and
    // whether done was high in the first idle cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [11:0] src, input logic [3:0] h,
                           input logic [6:0] x, input logic [5:0] y, input logic hr,
                           output int busy_n, output logic done_seen);
        blit_op        = op;
        blit_src       = src;
        blit_srcHeight = h;
        blit_destX     = x;
        blit_destY     = y;
        hires          = hr;
        blit_enable    = 1'b1;
        @(posedge clk);
        #1 blit_enable = 1'b0;
        busy_n = 0;
        while (blit_busy && busy_n < 3000) begin
            busy_n++;
            @(posedge clk);
            #1;
        end
        done_seen = blit_done;
    endtask

    int   busy_n;
    logic done_seen;

    initial begin
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) vram_mem[i] = 8'hA5;
        src_mem[12'h050] = 8'hF0;
        src_mem[12'h100] = 8'hFF;
        src_mem[12'h101] = 8'hFF;
        src_mem[12'h102] = 8'hFF;
        src_mem[12'h200] = 8'h81;
        src_mem[12'h300] = 8'h80;
        src_mem[12'h301] = 8'h40;
        for (int i = 0; i < 15; i++) src_mem[12'h400 + i] = 8'hFF;
        clear_log();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(blit_busy), 0);
        check("rst_done", 32'(blit_done), 0);
        check("rst_coll", 32'(blit_collision), 0);
        check("rst_ens", {29'd0, src_en, vram_en, vram_wr}, 0);
        check("rst_addrs", {10'd0, src_addr, vram_addr}, 0);
        check("rst_vram_in", 32'(vram_in), 0);

        // Full clear
        clear_log();
        run_cmd(BLIT_OP_CLEAR, 12'h000, 4'd0, 7'd0, 6'd0, 1'b0, busy_n, done_seen);
        check("clr_busy", 32'(busy_n), 1024);
        check("clr_done", 32'(done_seen), 1);
        check("clr_writes", 32'(wr_count), 1024);
        check("clr_seq", 32'(seq_bad), 0);
        check("clr_coll", 32'(blit_collision), 0);
        check("clr_mem_last", 32'(vram_mem[10'h3FF]), 0);
        @(posedge clk);
        #1 check("done_one_cycle", 32'(blit_done), 0);

        // Sprite F0 at (3,2) hires
        clear_log();
        run_cmd(BLIT_OP_SPRITE, 12'h050, 4'd1, 7'd3, 6'd2, 1'b1, busy_n, done_seen);
        check("spr1_busy", 32'(busy_n), 5);
        check("spr1_done", 32'(done_seen), 1);
        check("spr1_left", 32'(vram_mem[10'h020]), 32'h1E);
        check("spr1_right", 32'(vram_mem[10'h021]), 32'h00);
        check("spr1_coll", 32'(blit_collision), 0);

        // Same sprite again erases it and collides
        run_cmd(BLIT_OP_SPRITE, 12'h050, 4'd1, 7'd3, 6'd2, 1'b1, busy_n, done_seen);
        check("spr2_busy", 32'(busy_n), 5);
        check("spr2_left", 32'(vram_mem[10'h020]), 32'h00);
        check("spr2_right", 32'(vram_mem[10'h021]), 32'h00);
        check("spr2_coll", 32'(blit_collision), 1);

        // Clear drops the collision flag
        run_cmd(BLIT_OP_CLEAR, 12'h000, 4'd0, 7'd0, 6'd0, 1'b1, busy_n, done_seen);
        check("clr2_coll", 32'(blit_collision), 0);

        // Lores bottom-right corner: right byte and lower rows clipped
        clear_log();
        run_cmd(BLIT_OP_SPRITE, 12'h100, 4'd3, 7'd60, 6'd31, 1'b0, busy_n, done_seen);
        check("corner_busy", 32'(busy_n), 5);
        check("corner_byte", 32'(vram_mem[10'h1F7]), 32'h0F);
        check("corner_right", 32'(vram_mem[10'h1F8]), 32'h00);
        check("corner_writes", 32'(wr_count), 1);
        check("corner_addr", 32'(wr_log[0]), 32'h1F7);

        // Lores origin wrap: (70,40) -> (6,8)
        clear_log();
        run_cmd(BLIT_OP_SPRITE, 12'h200, 4'd1, 7'd70, 6'd40, 1'b0, busy_n, done_seen);
        check("wrap_writes", 32'(wr_count), 2);
        check("wrap_addr0", 32'(wr_log[0]), 32'h080);
        check("wrap_addr1", 32'(wr_log[1]), 32'h081);
        check("wrap_left", 32'(vram_mem[10'h080]), 32'h02);
        check("wrap_right", 32'(vram_mem[10'h081]), 32'h04);

        // Two byte-aligned rows in hires
        clear_log();
        run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd2, 7'd0, 6'd10, 1'b1, busy_n, done_seen);
        check("rows_busy", 32'(busy_n), 10);
        check("rows_writes", 32'(wr_count), 2);
        check("rows_r0", 32'(vram_mem[10'h0A0]), 32'h80);
        check("rows_r1", 32'(vram_mem[10'h0B0]), 32'h40);

        // Zero height and unknown opcode are one-cycle no-ops
        clear_log();
        run_cmd(BLIT_OP_SPRITE, 12'h300, 4'd0, 7'd0, 6'd10, 1'b1, busy_n, done_seen);
        check("h0_busy", 32'(busy_n), 1);
        check("h0_done", 32'(done_seen), 1);
        run_cmd(3'd5, 12'h000, 4'd1, 7'd0, 6'd0, 1'b1, busy_n, done_seen);
        check("nop_busy", 32'(busy_n), 1);
        check("nop_writes", 32'(wr_count), 0);

        // Reset during the third busy cycle of a 15-row sprite
        blit_op = BLIT_OP_SPRITE; blit_src = 12'h400; blit_srcHeight = 4'd15;
        blit_destX = 7'd0; blit_destY = 6'd0; hires = 1'b1;
        blit_enable = 1'b1;
        @(posedge clk);
        #1 blit_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", 32'(blit_busy), 0);
        check("abort_done", 32'(blit_done), 0);
        @(posedge clk);
        #1 check("abort_done2", 32'(blit_done), 0);

        clear_log();
        run_cmd(BLIT_OP_CLEAR, 12'h000, 4'd0, 7'd0, 6'd0, 1'b1, busy_n, done_seen);
        check("post_clr_busy", 32'(busy_n), 1024);
        check("post_clr_done", 32'(done_seen), 1);
        check("post_clr_writes", 32'(wr_count), 1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
